// File: rtl/shift_seq_if.sv
// Host-side command/response bundle for the shift-register sequencer.
interface shift_seq_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = 3
) ();
    logic             start;
    logic             dir;
    logic [SHW-1:0]   shamt;
    logic             fill;
    logic             rotate;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    // Host issues commands and observes the response
    modport master (
        output start, dir, shamt, fill, rotate, data_in,
        input  busy, done, result, ovf
    );

    // Sequencer accepts commands and reports the response
    modport slave (
        input  start, dir, shamt, fill, rotate, data_in,
        output busy, done, result, ovf
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a 4-bit universal shift register: load, shift n places, capture.
// Optional rotate support is compiled in with `define SHIFT_SEQ_ROTATE_EN.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = 3
) (
    input  logic             clk,
    input  logic             clr,
    shift_seq_if.slave       host,
    output logic             m0,
    output logic             m1,
    output logic [WIDTH-1:0] p_load,
    output logic             sr_left_in,
    output logic             sr_right_in,
    input  logic [WIDTH-1:0] sr_p_out
);

    localparam logic [SHW-1:0] MAX_SH = SHW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        CAPT  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   shamt_sat;
    logic             dir_q;
    logic             fill_q;
    logic             rot_on;
    logic             out_bit;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [WIDTH-1:0] result_q;
    logic             m0_d;
    logic             m1_d;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot_q;

    // Rotate request captured with the command
    always_ff @(posedge clk) begin
        if (clr) begin
            rot_q <= 1'b0;
        end else if (state == IDLE && host.start) begin
            rot_q <= host.rotate;
        end
    end

    assign rot_on = rot_q;
`else
    logic unused_rotate;
    assign unused_rotate = host.rotate;
    assign rot_on        = 1'b0;
`endif

    assign shamt_sat = (host.shamt > MAX_SH) ? MAX_SH : host.shamt;

    // Bit leaving the register on a shift edge
    assign out_bit = dir_q ? sr_p_out[WIDTH-1] : sr_p_out[0];

    // Serial inputs: fill, or the wrapped-around bit when rotating
    assign sr_left_in  = (rot_on && !dir_q) ? sr_p_out[0]       : fill_q;
    assign sr_right_in = (rot_on &&  dir_q) ? sr_p_out[WIDTH-1] : fill_q;

    assign host.busy   = busy_q;
    assign host.done   = done_q;
    assign host.ovf    = ovf_q;
    assign host.result = result_q;

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (host.start) state_next = LOAD;
            LOAD:    state_next = (cnt != '0) ? SHIFT : CAPT;
            SHIFT:   if (cnt == SHW'(1)) state_next = CAPT;
            CAPT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Mode pins decoded from the upcoming state so they register in step with it
    always_comb begin
        m0_d = 1'b0;
        m1_d = 1'b0;
        case (state_next)
            LOAD: begin
                m0_d = 1'b1;
                m1_d = 1'b1;
            end
            SHIFT: begin
                m0_d = dir_q;
                m1_d = ~dir_q;
            end
            default: begin
                m0_d = 1'b0;
                m1_d = 1'b0;
            end
        endcase
    end

    // Command registers, counter, mode pins and host response
    always_ff @(posedge clk) begin
        if (clr) begin
            m0       <= 1'b0;
            m1       <= 1'b0;
            p_load   <= '0;
            cnt      <= '0;
            dir_q    <= 1'b0;
            fill_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            m0     <= m0_d;
            m1     <= m1_d;
            done_q <= (state == CAPT);
            case (state)
                IDLE: begin
                    if (host.start) begin
                        dir_q  <= host.dir;
                        cnt    <= shamt_sat;
                        fill_q <= host.fill;
                        p_load <= host.data_in;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - SHW'(1);
                    if (!rot_on) begin
                        ovf_q <= ovf_q | out_bit;
                    end
                end
                CAPT: begin
                    result_q <= sr_p_out;
                    busy_q   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl with a behavioural shift-register plant.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       m0, m1, sr_left_in, sr_right_in;
    logic [3:0] p_load;
    logic [3:0] sr = 4'h0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [3:0] r;
        bit         o;
        int         done_cyc;
        int         n;
        bit         dir;
    } exp_t;

    exp_t sb[$];

    int nshift = 0;
    int nload  = 0;
    bit saw_r  = 0;
    bit saw_l  = 0;

    shift_seq_if #(.WIDTH(4), .SHW(3)) bus ();

    shift_seq_ctrl #(.WIDTH(4), .SHW(3)) dut (
        .clk         (clk),
        .clr         (clr),
        .host        (bus),
        .m0          (m0),
        .m1          (m1),
        .p_load      (p_load),
        .sr_left_in  (sr_left_in),
        .sr_right_in (sr_right_in),
        .sr_p_out    (sr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Universal shift register plant
    always @(posedge clk) begin
        case ({m0, m1})
            2'b11:   sr <= p_load;
            2'b01:   sr <= {sr_left_in, sr[3:1]};
            2'b10:   sr <= {sr[2:0], sr_right_in};
            default: sr <= sr;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: shift/rotate by n places computed arithmetically
    function automatic void model(input logic [3:0] d, input bit dr, input int n,
                                  input bit f, input bit rt,
                                  output logic [3:0] r, output bit o);
        int di   = int'(d);
        int fm   = f ? 15 : 0;
        int mask = (1 << n) - 1;
        int v;
        if (rt) begin
            if (dr) v = (di << n) | (di >> (4 - n));
            else    v = (di >> n) | (di << (4 - n));
            o = 1'b0;
        end else if (dr) begin
            v = (di << n) | (fm & mask);
            o = ((di >> (4 - n)) != 0);
        end else begin
            v = (di >> n) | (fm & ~(15 >> n));
            o = ((di & mask) != 0);
        end
        r = 4'(v & 15);
    endfunction

    // Called right after a negedge with the DUT idle; returns after the next negedge
    task automatic issue(input logic [3:0] d, input bit dr, input logic [2:0] sh,
                         input bit f, input bit rt);
        exp_t       e;
        logic [3:0] r;
        bit         o;
        bit         rt_eff;
        int         n;
        n = (int'(sh) > 4) ? 4 : int'(sh);
`ifdef SHIFT_SEQ_ROTATE_EN
        rt_eff = rt;
`else
        rt_eff = 1'b0;
`endif
        model(d, dr, n, f, rt_eff, r, o);
        e.r = r; e.o = o; e.n = n; e.dir = dr;
        e.done_cyc = cyc + 3 + n;
        sb.push_back(e);
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.dir     = dr;
        bus.shamt   = sh;
        bus.fill    = f;
        bus.rotate  = rt;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait for idle while throwing junk commands at the busy DUT
    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 40) begin
            bus.start   = 1'($urandom);
            bus.data_in = 4'($urandom);
            bus.dir     = 1'($urandom);
            bus.shamt   = 3'($urandom);
            bus.fill    = 1'($urandom);
            bus.rotate  = 1'($urandom);
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        if (bus.busy) chk("idle_timeout", 1, 0);
    endtask

    // Monitor: per-transaction mode tracking and scoreboard comparison on done
    always @(negedge clk) begin
        if (clr) begin
            nshift = 0; nload = 0; saw_r = 0; saw_l = 0;
        end else begin
            if ({m0, m1} == 2'b11) nload++;
            if ({m0, m1} == 2'b01) begin nshift++; saw_r = 1; end
            if ({m0, m1} == 2'b10) begin nshift++; saw_l = 1; end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    bit   dir_ok;
                    e = sb.pop_front();
                    if (e.n == 0)  dir_ok = !saw_r && !saw_l;
                    else if (e.dir) dir_ok = saw_l && !saw_r;
                    else            dir_ok = saw_r && !saw_l;
                    chk("result",     int'(bus.result), int'(e.r));
                    chk("ovf",        int'(bus.ovf),    int'(e.o));
                    chk("done_cycle", cyc,              e.done_cyc);
                    chk("shift_cyc",  nshift,           e.n);
                    chk("load_cyc",   nload,            1);
                    chk("shift_dir",  int'(dir_ok),     1);
                    chk("busy_at_done", int'(bus.busy), 0);
                end
                nshift = 0; nload = 0; saw_r = 0; saw_l = 0;
            end
        end
    end

    initial begin
        int k;
        clr         = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = 4'h0;
        bus.dir     = 1'b0;
        bus.shamt   = 3'd0;
        bus.fill    = 1'b0;
        bus.rotate  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   int'(bus.busy),   0);
        chk("rst_done",   int'(bus.done),   0);
        chk("rst_ovf",    int'(bus.ovf),    0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_mode",   int'({m0, m1}),   0);
        chk("rst_pload",  int'(p_load),     0);
        clr = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(4'b1011, 1'b0, 3'd1, 1'b0, 1'b0); wait_idle();
        issue(4'b0011, 1'b1, 3'd2, 1'b1, 1'b0); wait_idle();
        issue(4'b1001, 1'b0, 3'd0, 1'b1, 1'b0); wait_idle();
        issue(4'b1111, 1'b0, 3'd7, 1'b0, 1'b0); wait_idle();
        issue(4'b1000, 1'b1, 3'd1, 1'b0, 1'b1); wait_idle();
        issue(4'b0110, 1'b1, 3'd5, 1'b1, 1'b0); wait_idle();

        // Abort during the second shift cycle
        issue(4'b1111, 1'b0, 3'd4, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("abort_busy",   int'(bus.busy),   0);
        chk("abort_done",   int'(bus.done),   0);
        chk("abort_mode",   int'({m0, m1}),   0);
        chk("abort_result", int'(bus.result), 0);
        sb.delete();
        @(negedge clk);
        clr = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_idle", int'(bus.busy), 0);
        issue(4'b1010, 1'b0, 3'd2, 1'b1, 1'b0); wait_idle();

        // Random traffic, including back-to-back starts in the done cycle
        for (int i = 0; i < 200; i++) begin
            issue(4'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            wait_idle();
            k = int'($urandom_range(0, 2));
            repeat (k) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer for the 4-bit universal shift register (mode pins m0/m1, serial left_in/right_in, parallel p_in/p_out).
- Takes one command per transaction: parallel-load a word, shift it a programmed number of positions left or right, then capture the result.
- Sits between a host/FSM issuing start/done transactions and the shift register, which it owns exclusively.
- Mode encoding {m0,m1}: 00 hold, 01 shift right (left_in enters MSB), 10 shift left (right_in enters LSB), 11 parallel load.

Parameters:
- WIDTH, 4, shift register data width.
- SHW, 3, width of the shift-amount field; must satisfy 2^SHW > WIDTH.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- clr  in  1  reset.
- start  in  1  command strobe; sampled only in IDLE.
- dir  in  1  0 = shift right, 1 = shift left.
- shamt  in  SHW  shift count; values above WIDTH saturate to WIDTH.
- fill  in  1  serial fill bit.
- rotate  in  1  rotate request; honoured only when the optional feature is compiled in.
- data_in  in  WIDTH  word to load.
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  WIDTH  captured register value; holds until the next capture.
- ovf  out  1  a '1' was shifted out during the transaction; valid with done, held until the next start.
- m0, m1  out  1 each  mode pins to the shift register.
- p_load  out  WIDTH  parallel data to the shift register's p_in.
- sr_left_in, sr_right_in  out  1 each  serial inputs to the shift register.
- sr_p_out  in  WIDTH  shift register parallel output.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (clr=1 at posedge):
  - State to IDLE; busy, done, ovf, m0, m1 = 0; result, p_load = 0; counter cleared.
  - Wins over every other input, including mid-transaction. The aborted command produces no done.
- States: IDLE, LOAD, SHIFT, CAPT.
- IDLE:
  - Outputs m0m1 = 00.
  - On start=1: latch dir, saturated shamt, fill, rotate and data_in into command registers; clear ovf; set busy; go to LOAD.
- LOAD:
  - Drives m0m1 = 11 and p_load = latched data for exactly one cycle.
  - Next state is SHIFT if count > 0, else CAPT.
- SHIFT:
  - Drives m0m1 = 01 (dir=0) or 10 (dir=1) for exactly `count` cycles; the counter decrements each edge.
  - Goes to CAPT on the edge where the counter reaches 0.
  - On each SHIFT edge, ovf |= the bit leaving the register: sr_p_out[0] when shifting right, sr_p_out[WIDTH-1] when shifting left.
- Serial inputs: sr_left_in and sr_right_in are both driven with the latched fill, except when rotation is enabled (see Optional Feature).
- CAPT:
  - Drives m0m1 = 00.
  - At the edge: result <= sr_p_out, done = 1 for one cycle, busy = 0, return to IDLE.
- Latency: start sampled at edge E0 gives done high in the cycle after edge E(2+n), where n is the saturated shamt. Back-to-back: start may be reasserted in the done cycle and is accepted at that edge.
- start while busy is ignored (no queueing); command inputs are don't-care while busy.
- m0m1 = 11 appears only in LOAD. Shift modes appear only in SHIFT.

Optional Feature:
- Macro: SHIFT_SEQ_ROTATE_EN.
- Defined and latched rotate=1:
  - Right shift: sr_left_in = sr_p_out[0].
  - Left shift: sr_right_in = sr_p_out[WIDTH-1].
  - ovf is forced to 0.
- Undefined: the rotate input is ignored; fill is always used.

Test Plan:
- Load 4'b1011, dir=0, shamt=1, fill=0 -> m0m1 sequence 11,01,00; result 4'b0101; ovf=1; done 3 cycles after the start edge.
- Load 4'b0011, dir=1, shamt=2, fill=1 -> result 4'b1111; ovf=0; busy high for 4 cycles.
- shamt=0, data 4'b1001 -> LOAD then CAPT; result 4'b1001; done 2 cycles after start; no shift mode ever driven.
- shamt=7 (saturates to 4), dir=0, data 4'b1111, fill=0 -> exactly 4 shift cycles; result 4'b0000; ovf=1.
- clr asserted during the 2nd SHIFT cycle -> next cycle: IDLE, busy=0, m0m1=00, no done; a following start runs normally.
- With SHIFT_SEQ_ROTATE_EN and rotate=1: data 4'b1000, dir=1, shamt=1 -> result 4'b0001, ovf=0. Without the macro, the same command gives result 4'b0000 (fill=0) and ovf=1.
